// File: rtl/paint_write_arbiter_if.sv
// Pixel handshake and RAM write bus shared between two requesters and the paint arbiter.
// The arbiter uses the slave modport; the pixel sources and the RAM use the master view.
interface paint_write_arbiter_if #(
    parameter int unsigned ADDR_W = 19
);
    logic              a_valid;
    logic [9:0]        a_x;
    logic [8:0]        a_y;
    logic [2:0]        a_color;
    logic              a_ready;

    logic              b_valid;
    logic [9:0]        b_x;
    logic [8:0]        b_y;
    logic [2:0]        b_color;
    logic              b_ready;

    logic              ram_wren;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [2:0]        ram_wr_data;
    logic              oob_err;

    modport slave (
        input  a_valid, a_x, a_y, a_color,
        output a_ready,
        input  b_valid, b_x, b_y, b_color,
        output b_ready,
        output ram_wren, ram_wr_addr, ram_wr_data, oob_err
    );

    modport master (
        output a_valid, a_x, a_y, a_color,
        input  a_ready,
        output b_valid, b_x, b_y, b_color,
        input  b_ready,
        input  ram_wren, ram_wr_addr, ram_wr_data, oob_err
    );
endinterface

// File: rtl/paint_write_arbiter.sv
// Sole owner of the paint RAM write port: round-robin between requesters A and B,
// (x,y) to linear address, off-screen drop, and a full-screen clear sweep.
module paint_write_arbiter #(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480,
    parameter int unsigned ADDR_W = 19
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_req,
    output logic clear_busy,
    paint_write_arbiter_if.slave bus
);
    typedef enum logic {RUN, CLEAR} state_t;

    localparam logic [ADDR_W-1:0] W_A  = ADDR_W'(WIDTH);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WIDTH * HEIGHT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              prefer_b_q, prefer_b_d;
    logic              wren_q, wren_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        data_q, data_d;
    logic              oob_q, oob_d;
    logic              busy_q, busy_d;

    logic              a_rdy, b_rdy;
    logic [9:0]        px_x;
    logic [8:0]        px_y;
    logic [2:0]        px_c;
    logic              on_screen;

    // Clear request in RUN blocks both requesters so the clear wins a tie.
    always_comb begin
        a_rdy = 1'b0;
        b_rdy = 1'b0;
        if (state_q == RUN && !clear_req) begin
            if (bus.a_valid && bus.b_valid) begin
                a_rdy = !prefer_b_q;
                b_rdy = prefer_b_q;
            end else begin
                a_rdy = bus.a_valid;
                b_rdy = bus.b_valid;
            end
        end
    end

    assign px_x      = b_rdy ? bus.b_x     : bus.a_x;
    assign px_y      = b_rdy ? bus.b_y     : bus.a_y;
    assign px_c      = b_rdy ? bus.b_color : bus.a_color;
    assign on_screen = (32'(px_x) < WIDTH) && (32'(px_y) < HEIGHT);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        prefer_b_d = prefer_b_q;
        wren_d     = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        oob_d      = 1'b0;
        busy_d     = 1'b0;
        case (state_q)
            RUN: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
                if (a_rdy || b_rdy) begin
                    prefer_b_d = a_rdy;
                    if (on_screen) begin
                        wren_d = 1'b1;
                        addr_d = ADDR_W'(px_y) * W_A + ADDR_W'(px_x);
                        data_d = px_c;
                    end else begin
                        oob_d = 1'b1;
                    end
                end
            end
            CLEAR: begin
                wren_d = 1'b1;
                busy_d = 1'b1;
                addr_d = cnt_q;
                data_d = '0;
                if (cnt_q == LAST) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            prefer_b_q <= 1'b0;
            wren_q     <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            oob_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prefer_b_q <= prefer_b_d;
            wren_q     <= wren_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            oob_q      <= oob_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.a_ready     = a_rdy;
    assign bus.b_ready     = b_rdy;
    assign bus.ram_wren    = wren_q;
    assign bus.ram_wr_addr = addr_q;
    assign bus.ram_wr_data = data_q;
    assign bus.oob_err     = oob_q;
    assign clear_busy      = busy_q;
endmodule
